// File: rtl/hilo_mdu.sv
// Iterative HI/LO multiply-divide unit: 32-step shift-add / restoring divide, fixed 33-cycle busy.
// Optional HILO_MDU_DIV0_FLAG_EN: divide-by-zero skips CALC, leaves HI/LO alone and pulses div0_o.
module hilo_mdu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src0_i,
  input  logic [31:0] src1_i,
  input  logic        wr_hi_i,
  input  logic        wr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o
`ifdef HILO_MDU_DIV0_FLAG_EN
  ,
  output logic        div0_o
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        s0_q, s0_d, s1_q, s1_d;
  logic [31:0] b_q, b_d;
  logic [63:0] p_q, p_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        wr_res;

  logic        src0_neg, src1_neg;
  logic [31:0] mag0, mag1;
  logic [32:0] mul_sum, div_shl, div_dif;
  logic [63:0] mul_res;
  logic [31:0] quo, rem;

  // Signed ops work on magnitudes; the signs are reapplied in FIX.
  assign src0_neg = ~op_i[0] & src0_i[31];
  assign src1_neg = ~op_i[0] & src1_i[31];
  assign mag0     = src0_neg ? (~src0_i + 32'd1) : src0_i;
  assign mag1     = src1_neg ? (~src1_i + 32'd1) : src1_i;

  assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
  assign div_shl  = {p_q[63:32], p_q[31]};
  assign div_dif  = div_shl - {1'b0, b_q};

  assign mul_res  = (s0_q ^ s1_q) ? (~p_q + 64'd1) : p_q;
  assign quo      = (s0_q ^ s1_q) ? (~p_q[31:0] + 32'd1) : p_q[31:0];
  assign rem      = s0_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];

`ifdef HILO_MDU_DIV0_FLAG_EN
  logic dz_q, dz_d, div0_q, div0_d;
  assign wr_res = ~dz_q;
  assign div0_o = div0_q;
`else
  assign wr_res = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    b_d      = b_q;
    p_d      = p_q;
    hi_d     = wr_hi_i ? wdata_i : hi_q;
    lo_d     = wr_lo_i ? wdata_i : lo_q;
    done_d   = 1'b0;
`ifdef HILO_MDU_DIV0_FLAG_EN
    dz_d     = dz_q;
    div0_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          is_div_d = op_i[1];
          s0_d     = src0_neg;
          s1_d     = src1_neg;
          cnt_d    = 5'd0;
          // p holds {partial, multiplier} or {remainder, dividend/quotient}
          b_d      = op_i[1] ? mag1 : mag0;
          p_d      = {32'd0, (op_i[1] ? mag0 : mag1)};
          state_d  = CALC;
`ifdef HILO_MDU_DIV0_FLAG_EN
          dz_d     = op_i[1] && (src1_i == 32'd0);
          if (op_i[1] && (src1_i == 32'd0)) state_d = FIX;
`endif
        end
      end
      CALC: begin
        if (!is_div_q)        p_d = {mul_sum, p_q[31:1]};
        else if (div_dif[32]) p_d = {div_shl[31:0], p_q[30:0], 1'b0};
        else                  p_d = {div_dif[31:0], p_q[30:0], 1'b1};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef HILO_MDU_DIV0_FLAG_EN
        div0_d  = dz_q;
`endif
        // Result write overrides a same-edge MTHI/MTLO.
        if (wr_res) begin
          hi_d = is_div_q ? rem : mul_res[63:32];
          lo_d = is_div_q ? quo : mul_res[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      b_q      <= 32'd0;
      p_q      <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef HILO_MDU_DIV0_FLAG_EN
      dz_q     <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      b_q      <= b_d;
      p_q      <= p_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef HILO_MDU_DIV0_FLAG_EN
      dz_q     <= dz_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed vectors plus randomized ops against a longint arithmetic model.
module tb_hilo_mdu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src0_i, src1_i;
  logic        wr_hi_i, wr_lo_i;
  logic [31:0] wdata_i;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o;
`ifdef HILO_MDU_DIV0_FLAG_EN
  logic        div0_o;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  hilo_mdu dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .op_i    (op_i),
    .src0_i  (src0_i),
    .src1_i  (src1_i),
    .wr_hi_i (wr_hi_i),
    .wr_lo_i (wr_lo_i),
    .wdata_i (wdata_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
`ifdef HILO_MDU_DIV0_FLAG_EN
    ,
    .div0_o  (div0_o)
`endif
  );

  // Reference: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) begin
          q = (sa < 0) ? -longint'(32'hFFFF_FFFF) : longint'(32'hFFFF_FFFF);
          r = sa;
        end else begin
          q = sa / sb;
          r = sa % sb;
        end
        res = {r[31:0], q[31:0]};
      end
      default: res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 100);
      2: v = 32'd0 - $urandom_range(1, 100);
      default: v = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
    endcase
    return v;
  endfunction

  // Runs one op starting from a post-edge point; returns at the first non-busy sample.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit collide,
                       output int nbusy, output bit stable, output logic [31:0] hi, output logic [31:0] lo,
                       output logic dn, output logic d0);
    logic [31:0] h0, l0;
    h0 = hi_o;
    l0 = lo_o;
    start_i = 1'b1; op_i = op; src0_i = a; src1_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; op_i = 2'($urandom); src0_i = $urandom; src1_i = $urandom;
    nbusy = 0;
    stable = 1'b1;
    while (busy_o && nbusy < 40) begin
      nbusy++;
      if (hi_o !== h0 || lo_o !== l0) stable = 1'b0;
      if (collide && nbusy == 33) begin wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = $urandom; end
      @(posedge clk_i); #1;
      wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    end
    hi = hi_o;
    lo = lo_o;
    dn = done_o;
`ifdef HILO_MDU_DIV0_FLAG_EN
    d0 = div0_o;
`else
    d0 = 1'b0;
`endif
  endtask

  task automatic test_reset();
    int nb; bit st; logic [31:0] hi, lo; logic dn, d0;
    rst_n_i = 1'b0; start_i = 1'b0; op_i = 2'b00; src0_i = 32'd0; src1_i = 32'd0;
    wr_hi_i = 1'b0; wr_lo_i = 1'b0; wdata_i = 32'd0;
    #2;
    checks++;
    if ({hi_o, lo_o, busy_o, done_o} !== 66'd0)
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all zero", hi_o, lo_o, busy_o, done_o);
    else passed++;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    do_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, nb, st, hi, lo, dn, d0);
    checks++;
    if (!(nb == 33 && dn === 1'b1 && st))
      $display("FAIL first_mult_timing: busy=%0d done=%b stable=%b, want 33/1/1", nb, dn, st);
    else passed++;
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA)
      $display("FAIL first_mult_result: got %h_%h, want ffffffff_fffffffa", hi, lo);
    else passed++;
    @(posedge clk_i); #1;
    checks++;
    if (done_o !== 1'b0) $display("FAIL done_one_cycle: done=%b, want 0", done_o);
    else passed++;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] ex  [5] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003,
                             64'h0000_0000_8000_0000, 64'h4000_0000_0000_0000};
    int nb; bit st; logic [31:0] hi, lo; logic dn, d0;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, nb, st, hi, lo, dn, d0);
      checks++;
      if ({hi, lo} !== ex[i] || nb != 33 || dn !== 1'b1)
        $display("FAIL directed_%0d: got %h_%h busy=%0d done=%b, want %h busy=33 done=1", i, hi, lo, nb, dn, ex[i]);
      else passed++;
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h, l;
    h = $urandom; l = $urandom;
    wr_hi_i = 1'b1; wdata_i = h; @(posedge clk_i); #1; wr_hi_i = 1'b0;
    checks++;
    if (hi_o !== h) $display("FAIL mthi: hi=%h, want %h", hi_o, h); else passed++;
    wr_lo_i = 1'b1; wdata_i = l; @(posedge clk_i); #1; wr_lo_i = 1'b0;
    checks++;
    if ({hi_o, lo_o} !== {h, l}) $display("FAIL mtlo: got %h_%h, want %h_%h", hi_o, lo_o, h, l); else passed++;
    wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = ~h; @(posedge clk_i); #1; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    checks++;
    if ({hi_o, lo_o} !== {~h, ~h}) $display("FAIL mthi_mtlo_both: got %h_%h, want %h_%h", hi_o, lo_o, ~h, ~h);
    else passed++;
  endtask

  task automatic test_random();
    int nb; bit st; logic [31:0] hi, lo, a, b; logic dn, d0; logic [1:0] op; logic [63:0] ex;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      a = pick(); b = pick();
      if (op[1] && b == 32'd0) b = 32'd1;
      ex = model(op, a, b);
      do_op(op, a, b, 1'b0, nb, st, hi, lo, dn, d0);
      checks++;
      if (!(nb == 33 && dn === 1'b1 && st && d0 === 1'b0))
        $display("FAIL rand_timing_%0d: busy=%0d done=%b stable=%b div0=%b, want 33/1/1/0", i, nb, dn, st, d0);
      else passed++;
      checks++;
      if ({hi, lo} !== ex)
        $display("FAIL rand_result_%0d: op=%0d a=%h b=%h got %h_%h, want %h", i, op, a, b, hi, lo, ex);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int nb; bit st; logic [31:0] hi, lo, a, b; logic dn, d0;
    for (int i = 0; i < 3; i++) begin
      a = pick(); b = pick() | 32'd1;
      do_op(2'(i + 1), a, b, 1'b0, nb, st, hi, lo, dn, d0);
      checks++;
      if (nb != 33 || dn !== 1'b1 || {hi, lo} !== model(2'(i + 1), a, b))
        $display("FAIL back_to_back_%0d: busy=%0d done=%b got %h_%h, want 33/1 %h", i, nb, dn, hi, lo,
                 model(2'(i + 1), a, b));
      else passed++;
    end
  endtask

  task automatic test_collision();
    int nb; bit st; logic [31:0] hi, lo, a, b; logic dn, d0;
    a = pick(); b = pick();
    do_op(2'b00, a, b, 1'b1, nb, st, hi, lo, dn, d0);
    checks++;
    if ({hi, lo} !== model(2'b00, a, b))
      $display("FAIL collision: got %h_%h, want %h", hi, lo, model(2'b00, a, b));
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int cyc; bit ok;
    start_i = 1'b1; op_i = 2'b11; src0_i = 32'd100; src1_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0; ok = 1'b1;
    while (busy_o && cyc < 40) begin
      cyc++;
      if (cyc > 20 && lo_o !== 32'h55) ok = 1'b0;
      start_i = (cyc == 10);
      if (cyc == 10) begin op_i = 2'b00; src0_i = 32'd3; src1_i = 32'd3; end
      wr_lo_i = (cyc == 20);
      wdata_i = 32'h55;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0; wr_lo_i = 1'b0;
    checks++;
    if (!(cyc == 33 && ok && done_o === 1'b1))
      $display("FAIL busy_ignore_timing: busy=%0d lo55_held=%b done=%b, want 33/1/1", cyc, ok, done_o);
    else passed++;
    checks++;
    if ({hi_o, lo_o} !== {32'd2, 32'd14})
      $display("FAIL busy_ignore_result: got %h_%h, want 00000002_0000000e", hi_o, lo_o);
    else passed++;
    @(posedge clk_i); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL busy_ignore_no_queue: busy=%b done=%b, want 0/0", busy_o, done_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int nb, spurious; bit st; logic [31:0] hi, lo; logic dn, d0;
    wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'hA5A5_A5A5; @(posedge clk_i); #1;
    wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    start_i = 1'b1; op_i = 2'b00; src0_i = 32'd1234; src1_i = 32'd5678;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({hi_o, lo_o, busy_o, done_o} !== 66'd0)
      $display("FAIL reset_mid_outputs: hi=%h lo=%h busy=%b done=%b, want all zero", hi_o, lo_o, busy_o, done_o);
    else passed++;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) $display("FAIL reset_mid_no_done: %0d cycles with done/busy, want 0", spurious);
    else passed++;
    do_op(2'b00, 32'd1234, 32'hFFFF_FFFB, 1'b0, nb, st, hi, lo, dn, d0);
    checks++;
    if (nb != 33 || dn !== 1'b1 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_E7E6)
      $display("FAIL reset_mid_next_op: busy=%0d done=%b got %h_%h, want 33/1 ffffffffffffe7e6", nb, dn, hi, lo);
    else passed++;
  endtask

  task automatic test_div0();
    int nb; bit st; logic [31:0] hi, lo; logic dn, d0;
    wr_hi_i = 1'b1; wdata_i = 32'h1111; @(posedge clk_i); #1; wr_hi_i = 1'b0;
    wr_lo_i = 1'b1; wdata_i = 32'h2222; @(posedge clk_i); #1; wr_lo_i = 1'b0;
    do_op(2'b11, 32'd5, 32'd0, 1'b0, nb, st, hi, lo, dn, d0);
`ifdef HILO_MDU_DIV0_FLAG_EN
    checks++;
    if (!(nb == 1 && dn === 1'b1 && d0 === 1'b1))
      $display("FAIL div0_flag_timing: busy=%0d done=%b div0=%b, want 1/1/1", nb, dn, d0);
    else passed++;
    checks++;
    if ({hi, lo} !== {32'h1111, 32'h2222})
      $display("FAIL div0_flag_hold: got %h_%h, want 00001111_00002222", hi, lo);
    else passed++;
    @(posedge clk_i); #1;
    checks++;
    if (div0_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL div0_flag_pulse: div0=%b done=%b, want 0/0", div0_o, done_o);
    else passed++;
`else
    checks++;
    if (nb != 33 || dn !== 1'b1 || {hi, lo} !== {32'd5, 32'hFFFF_FFFF})
      $display("FAIL divu0: busy=%0d done=%b got %h_%h, want 33/1 00000005_ffffffff", nb, dn, hi, lo);
    else passed++;
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, nb, st, hi, lo, dn, d0);
    checks++;
    if (nb != 33 || dn !== 1'b1 || {hi, lo} !== {32'hFFFF_FFFB, 32'h0000_0001})
      $display("FAIL div0_signed: busy=%0d done=%b got %h_%h, want 33/1 fffffffb_00000001", nb, dn, hi, lo);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_random();
    test_back_to_back();
    test_collision();
    test_busy_ignore();
    test_reset_mid();
    test_div0();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
